// File: rtl/hub75_bcm_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : hub75_bcm_driver                                              |
// | Purpose  : HUB75 LED panel scanner with binary code modulation. Fetches  |
// |            DEPTH-bit RGB pixels for the top and bottom row halves from a |
// |            synchronous framebuffer, shifts one bit plane per pass, and   |
// |            shows plane b for BASE_ON<<b cycles. The shift of the next    |
// |            plane overlaps the display of the current one.                |
// | Ports    : clk, rst_n        - clock, async active-low reset             |
// |            enable, blank     - run scanning / force panel dark           |
// |            rd_en,rd_x,rd_row - framebuffer read request                  |
// |            rd_top, rd_bot    - pixel data, valid the cycle after rd_en   |
// |            hclk,lat,oe_n,addr- panel control pins                        |
// |            r0,g0,b0,r1,g1,b1 - panel colour bits (top / bottom)          |
// |            frame_start       - pulse on the latch of row 0, plane 0      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module hub75_bcm_driver #(
  parameter int COLS      = 64,
  parameter int ADDR_BITS = 5,
  parameter int DEPTH     = 4,
  parameter int BASE_ON   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     blank,
  output logic                     rd_en,
  output logic [$clog2(COLS)-1:0]  rd_x,
  output logic [ADDR_BITS-1:0]     rd_row,
  input  logic [3*DEPTH-1:0]       rd_top,
  input  logic [3*DEPTH-1:0]       rd_bot,
  output logic                     hclk,
  output logic                     lat,
  output logic                     oe_n,
  output logic [ADDR_BITS-1:0]     addr,
  output logic                     r0,
  output logic                     g0,
  output logic                     b0,
  output logic                     r1,
  output logic                     g1,
  output logic                     b1,
  output logic                     frame_start
);

  localparam int CW = $clog2(COLS);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2(BASE_ON << (DEPTH - 1)) + 1;

  localparam logic [CW-1:0] C_COL_LAST   = CW'(COLS - 1);
  localparam logic [PW-1:0] C_PLANE_LAST = PW'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_LOAD    = 3'd2,
    S_CLK_HI  = 3'd3,
    S_WAIT_ON = 3'd4,
    S_LATCH   = 3'd5,
    S_RUN     = 3'd6,
    S_DRAIN   = 3'd7
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          col_q, col_d;
  logic [PW-1:0]          plane_q, plane_d;
  logic [ADDR_BITS-1:0]   row_q, row_d;
  logic [TW-1:0]          timer_q, timer_d;

  logic                   rd_en_q, rd_en_d;
  logic [CW-1:0]          rd_x_q, rd_x_d;
  logic [ADDR_BITS-1:0]   rd_row_q, rd_row_d;
  logic                   hclk_q, hclk_d;
  logic                   lat_q, lat_d;
  logic                   oe_n_q, oe_n_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [2:0]             rgb0_q, rgb0_d;
  logic [2:0]             rgb1_q, rgb1_d;
  logic                   fs_q, fs_d;

  // Shifting the pixel word down by the plane index puts the current plane's
  // R, G and B bits at fixed positions 2*DEPTH, DEPTH and 0.
  logic [3*DEPTH-1:0]     top_sh_w, bot_sh_w;
  assign top_sh_w = rd_top >> plane_q;
  assign bot_sh_w = rd_bot >> plane_q;

  // Outputs are registered against the next state, so each output shows the
  // value belonging to the state the FSM is in during that same cycle.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    plane_d = plane_q;
    row_d   = row_q;
    timer_d = (timer_q != '0) ? timer_q - TW'(1) : timer_q;

    case (state_q)
      S_IDLE:    if (enable) state_d = S_FETCH;
      S_FETCH:   state_d = S_LOAD;
      S_LOAD:    state_d = S_CLK_HI;
      S_CLK_HI: begin
        if (col_q == C_COL_LAST) begin
          col_d   = '0;
          state_d = S_WAIT_ON;
        end else begin
          col_d   = col_q + CW'(1);
          state_d = S_FETCH;
        end
      end
      S_WAIT_ON: if (timer_q == '0) state_d = S_LATCH;
      S_LATCH: begin
        // Load the on-time of the plane being latched, then move the shift
        // pointers on so the next plane can be shifted during its display.
        timer_d = TW'(BASE_ON) << plane_q;
        if (plane_q == C_PLANE_LAST) begin
          plane_d = '0;
          row_d   = row_q + ADDR_BITS'(1);
        end else begin
          plane_d = plane_q + PW'(1);
        end
        state_d = S_RUN;
      end
      S_RUN:     state_d = enable ? S_FETCH : S_DRAIN;
      S_DRAIN: begin
        if (timer_q == '0) begin
          plane_d = '0;
          row_d   = '0;
          state_d = S_IDLE;
        end
      end
      default:   state_d = S_IDLE;
    endcase

    rd_en_d  = (state_d == S_FETCH);
    rd_x_d   = rd_x_q;
    rd_row_d = rd_row_q;
    if (state_d == S_FETCH) begin
      rd_x_d   = col_d;
      rd_row_d = row_d;
    end

    hclk_d = (state_d == S_CLK_HI);
    lat_d  = (state_d == S_LATCH);
    addr_d = (state_d == S_LATCH) ? row_q : addr_q;
    fs_d   = (state_d == S_LATCH) && (row_q == '0) && (plane_q == '0);

    // Registering straight from the blank input gives oe_n exactly one cycle
    // of latency to blank; the panel is dark whenever no on-time remains.
    oe_n_d = (timer_d == '0) || blank || (state_d == S_LATCH);

    // Framebuffer data arrives during LOAD and is captured at its end, so it
    // is on the pins for the whole CLK_HI cycle and the following FETCH.
    rgb0_d = rgb0_q;
    rgb1_d = rgb1_q;
    if (state_q == S_LOAD) begin
      rgb0_d = {top_sh_w[2*DEPTH], top_sh_w[DEPTH], top_sh_w[0]};
      rgb1_d = {bot_sh_w[2*DEPTH], bot_sh_w[DEPTH], bot_sh_w[0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      col_q    <= '0;
      plane_q  <= '0;
      row_q    <= '0;
      timer_q  <= '0;
      rd_en_q  <= 1'b0;
      rd_x_q   <= '0;
      rd_row_q <= '0;
      hclk_q   <= 1'b0;
      lat_q    <= 1'b0;
      oe_n_q   <= 1'b1;
      addr_q   <= '0;
      rgb0_q   <= '0;
      rgb1_q   <= '0;
      fs_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      plane_q  <= plane_d;
      row_q    <= row_d;
      timer_q  <= timer_d;
      rd_en_q  <= rd_en_d;
      rd_x_q   <= rd_x_d;
      rd_row_q <= rd_row_d;
      hclk_q   <= hclk_d;
      lat_q    <= lat_d;
      oe_n_q   <= oe_n_d;
      addr_q   <= addr_d;
      rgb0_q   <= rgb0_d;
      rgb1_q   <= rgb1_d;
      fs_q     <= fs_d;
    end
  end

  assign rd_en       = rd_en_q;
  assign rd_x        = rd_x_q;
  assign rd_row      = rd_row_q;
  assign hclk        = hclk_q;
  assign lat         = lat_q;
  assign oe_n        = oe_n_q;
  assign addr        = addr_q;
  assign {r0, g0, b0} = rgb0_q;
  assign {r1, g1, b1} = rgb1_q;
  assign frame_start = fs_q;

endmodule
`default_nettype wire

// File: tb/tb_hub75_bcm_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_hub75_bcm_driver                                           |
// | Purpose  : Directed self-checking bench for hub75_bcm_driver with        |
// |            COLS=4, ADDR_BITS=1, DEPTH=2, BASE_ON=32. Records every output |
// |            per cycle, then compares against a hand-computed timeline.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_hub75_bcm_driver;

  localparam int COLS      = 4;
  localparam int ADDR_BITS = 1;
  localparam int DEPTH     = 2;
  localparam int BASE_ON   = 32;
  localparam int NCYC      = 690;
  localparam int NLAT      = 14;
  localparam int NFS       = 4;

  logic                 clk = 1'b0;
  logic                 rst_n, enable, blank;
  logic                 rd_en;
  logic [1:0]           rd_x;
  logic [ADDR_BITS-1:0] rd_row;
  logic [3*DEPTH-1:0]   rd_top, rd_bot;
  logic                 hclk, lat, oe_n;
  logic [ADDR_BITS-1:0] addr;
  logic                 r0, g0, b0, r1, g1, b1;
  logic                 frame_start;

  int checks   = 0;
  int failures = 0;

  // Per-cycle history, index = cycles since enable was first raised.
  logic       h_rden [0:NCYC];
  logic [1:0] h_rdx  [0:NCYC];
  logic       h_rdrow[0:NCYC];
  logic       h_hclk [0:NCYC];
  logic       h_lat  [0:NCYC];
  logic       h_oe   [0:NCYC];
  logic       h_addr [0:NCYC];
  logic       h_fs   [0:NCYC];
  logic [2:0] h_top  [0:NCYC];
  logic [2:0] h_bot  [0:NCYC];

  // Latch instants: plane period max(13, 32<<b)+2 -> 34 / 66 cycles.
  int exp_lat  [NLAT] = '{14, 48, 114, 148, 214, 248, 314, 348, 414, 448, 514, 574, 608, 674};
  int exp_addr [NLAT] = '{ 0,  0,   1,   1,   0,   0,   1,   1,   0,   0,   1,   0,   0,   1};
  int exp_fs   [NFS]  = '{14, 214, 414, 574};

  always #5 clk = ~clk;

  hub75_bcm_driver #(
    .COLS(COLS), .ADDR_BITS(ADDR_BITS), .DEPTH(DEPTH), .BASE_ON(BASE_ON)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .blank(blank),
    .rd_en(rd_en), .rd_x(rd_x), .rd_row(rd_row),
    .rd_top(rd_top), .rd_bot(rd_bot),
    .hclk(hclk), .lat(lat), .oe_n(oe_n), .addr(addr),
    .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
    .frame_start(frame_start)
  );

  // Synchronous framebuffer for the bottom half: R = x, G = ~x, B = 0.
  always @(posedge clk) begin
    if (rd_en) rd_bot <= {rd_x, ~rd_x, 2'b00};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int cnt_oe_low(input int a, input int b);
    int n = 0;
    for (int c = a; c <= b; c++) if (h_oe[c] === 1'b0) n++;
    return n;
  endfunction

  function automatic int cnt_hi(input int a, input int b, input bit sel_rden);
    int n = 0;
    for (int c = a; c <= b; c++) begin
      if (sel_rden && h_rden[c] === 1'b1) n++;
      if (!sel_rden && h_hclk[c] === 1'b1) n++;
    end
    return n;
  endfunction

  initial begin
    int lat_seen[$];
    int fs_seen[$];
    int h;
    int f;

    rst_n  = 1'b0;
    enable = 1'b0;
    blank  = 1'b0;
    rd_top = 6'b10_01_11;
    rd_bot = '0;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_oe_n", oe_n, 1);
    chk("rst_lat", lat, 0);
    chk("rst_hclk", hclk, 0);
    chk("rst_addr", addr, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_x", rd_x, 0);
    chk("rst_rd_row", rd_row, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_colour", {r0, g0, b0, r1, g1, b1}, 0);

    // Idle with enable low: nothing moves.
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("idle_oe_n", oe_n, 1);
    chk("idle_rd_en", rd_en, 0);
    chk("idle_hclk", hclk, 0);

    enable = 1'b1;
    for (int c = 1; c <= NCYC; c++) begin
      @(posedge clk);
      #1;
      h_rden[c]  = rd_en;
      h_rdx[c]   = rd_x;
      h_rdrow[c] = rd_row;
      h_hclk[c]  = hclk;
      h_lat[c]   = lat;
      h_oe[c]    = oe_n;
      h_addr[c]  = addr;
      h_fs[c]    = frame_start;
      h_top[c]   = {r0, g0, b0};
      h_bot[c]   = {r1, g1, b1};
      case (c)
        430: blank  = 1'b1;
        440: blank  = 1'b0;
        452: enable = 1'b0;
        560: enable = 1'b1;
        680: rst_n  = 1'b0;
        default: ;
      endcase
    end

    // First plane-0 shift: FETCH/LOAD/CLK_HI per column, no display yet.
    for (int c = 1; c <= 13; c++)
      chk($sformatf("p0_hclk_c%0d", c), h_hclk[c], (c % 3 == 0) ? 1 : 0);
    chk("pre_latch_dark", cnt_oe_low(1, 14), 0);
    for (int k = 0; k < 4; k++) begin
      f = 1 + 3 * k;
      h = 3 + 3 * k;
      chk($sformatf("p0_rd_en_k%0d", k), h_rden[f], 1);
      chk($sformatf("p0_rd_x_k%0d", k), h_rdx[f], k);
      chk($sformatf("p0_rd_row_k%0d", k), h_rdrow[f], 0);
      chk($sformatf("p0_top_k%0d", k), h_top[h], 3'b011);
      chk($sformatf("p0_bot_k%0d", k), h_bot[h], {k[0], ~k[0], 1'b0});
      h = 18 + 3 * k;
      chk($sformatf("p1_hclk_k%0d", k), h_hclk[h], 1);
      chk($sformatf("p1_top_k%0d", k), h_top[h], 3'b101);
      chk($sformatf("p1_bot_k%0d", k), h_bot[h], {k[1], ~k[1], 1'b0});
    end
    chk("p1_hclk_count", cnt_hi(16, 28, 1'b0), 4);
    chk("row1_rd_en", h_rden[50], 1);
    chk("row1_rd_row", h_rdrow[50], 1);

    // Latch instants, addresses and dark latch cycles.
    for (int c = 1; c <= NCYC; c++) begin
      if (h_lat[c] === 1'b1) lat_seen.push_back(c);
      if (h_fs[c] === 1'b1) fs_seen.push_back(c);
    end
    chk("latch_count", lat_seen.size(), NLAT);
    for (int i = 0; i < NLAT && i < lat_seen.size(); i++) begin
      chk($sformatf("latch_cycle_%0d", i), lat_seen[i], exp_lat[i]);
      chk($sformatf("latch_addr_%0d", i), h_addr[exp_lat[i]], exp_addr[i]);
      chk($sformatf("latch_oe_n_%0d", i), h_oe[exp_lat[i]], 1);
    end
    chk("frame_start_count", fs_seen.size(), NFS);
    for (int i = 0; i < NFS && i < fs_seen.size(); i++)
      chk($sformatf("frame_start_cycle_%0d", i), fs_seen[i], exp_fs[i]);

    // BCM on-times: 32 cycles for plane 0, 64 for plane 1.
    chk("p0_on_cycles", cnt_oe_low(15, 46), 32);
    chk("p0_off_after", h_oe[47], 1);
    chk("p1_on_cycles", cnt_oe_low(49, 112), 64);
    chk("p1_off_after", h_oe[113], 1);

    // blank high for iterations 430..439 of the plane shown from cycle 415.
    chk("blank_before", h_oe[430], 0);
    chk("blank_dark_cycles", cnt_oe_low(431, 440), 0);
    chk("blank_after", h_oe[441], 0);
    chk("blank_resume_cycles", cnt_oe_low(441, 446), 6);
    chk("blank_end_of_plane", h_oe[447], 1);

    // enable dropped at 452 mid-shift: shift completes, plane shown, drain.
    chk("drop_hclk_count", cnt_hi(450, 461, 1'b0), 4);
    chk("drop_on_cycles", cnt_oe_low(515, 546), 32);
    chk("drop_dark_after", h_oe[547], 1);
    chk("drop_no_fetch", cnt_hi(516, 560, 1'b1), 0);
    chk("drop_no_hclk", cnt_hi(516, 560, 1'b0), 0);
    chk("restart_rd_en", h_rden[561], 1);
    chk("restart_rd_row", h_rdrow[561], 0);
    chk("restart_rd_x", h_rdx[561], 0);

    // Reset asserted at 680 while row 1 is lit and plane 1 is shifting.
    chk("mid_pre_addr", h_addr[680], 1);
    chk("mid_pre_oe_n", h_oe[680], 0);
    chk("mid_rst_oe_n", h_oe[681], 1);
    chk("mid_rst_lat", h_lat[681], 0);
    chk("mid_rst_hclk", h_hclk[681], 0);
    chk("mid_rst_addr", h_addr[681], 0);
    chk("mid_rst_rd_en", h_rden[681], 0);
    chk("mid_rst_rd_x", h_rdx[681], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hub75_bcm_driver.md
Name: hub75_bcm_driver

Overview:
- Parametrised successor to the single-bit HUB75 panel scanner.
- Drives a 1/2^ADDR_BITS-scan HUB75 panel of COLS columns, two row halves (top/bottom).
- Displays DEPTH-bit-per-colour pixels with binary code modulation (BCM), fetching pixels from an external synchronous framebuffer through a read port.
- Sits between the framebuffer RAM and the panel pins. The top level instantiates it on the PLL clock.

Parameters:
- COLS, 64, pixels shifted per row; power of two, ≥2.
- ADDR_BITS, 5, panel row-address width; scan rows = 2**ADDR_BITS.
- DEPTH, 4, bits per colour channel (BCM planes), 1..8.
- BASE_ON, 8, display cycles of plane 0; plane b shows BASE_ON<<b cycles; ≥1.

Ports:
- clk  in  1  Pixel/system clock; all logic on its rising edge.
- rst_n  in  1  Asynchronous active-low reset; async assert, sync deassert.
- enable  in  1  Run scanning; sampled only at plane boundaries.
- blank  in  1  Force panel dark; timing continues.
- rd_en  out  1  Framebuffer read strobe.
- rd_x  out  log2(COLS)  Column being read.
- rd_row  out  ADDR_BITS  Scan row being read; top half = rd_row, bottom = rd_row+2**ADDR_BITS.
- rd_top  in  3*DEPTH  Top pixel {R,G,B}, each DEPTH bits MSB-first; valid the cycle after rd_en.
- rd_bot  in  3*DEPTH  Bottom pixel, same layout and timing.
- hclk  out  1  Panel shift clock (CL).
- lat  out  1  Panel latch (LA).
- oe_n  out  1  Panel output enable, active low (BL).
- addr  out  ADDR_BITS  Panel row address (A0..).
- r0,g0,b0,r1,g1,b1  out  1 each  Top/bottom colour bits.
- frame_start  out  1  One-cycle pulse when row 0 plane 0 is latched.

Behaviour:
- All outputs are registered.
- Reset values: hclk=0, lat=0, oe_n=1, addr=0, colour bits=0, rd_en=0, rd_x=0, rd_row=0, frame_start=0. Internal column/plane/row/timer are 0 and the FSM is IDLE.
- Reset mid-operation aborts immediately to these values. There is no partial latch.
- Shift FSM states and transitions:
  - IDLE: leave when enable=1 → FETCH.
  - FETCH: rd_en=1, rd_x=col, rd_row=shift_row; hclk=0 → LOAD.
  - LOAD: rd_en=0; r0=rd_top[2*DEPTH+plane], g0=rd_top[DEPTH+plane], b0=rd_top[plane]; r1/g1/b1 likewise from rd_bot; hclk stays 0 → CLK_HI.
  - CLK_HI: hclk=1. If col==COLS-1: col=0 → WAIT_ON. Otherwise col+1 → FETCH.
  - WAIT_ON: hclk=0; hold until on-timer==0 → LATCH.
  - LATCH: oe_n=1, lat=1, addr=shift_row → RUN for one cycle.
  - RUN: lat=0, oe_n=blank_q, on-timer=BASE_ON<<plane. Advance plane; at plane==DEPTH-1 set plane=0 and shift_row+1, wrapping 2**ADDR_BITS-1→0. If enable=1 → FETCH, else → DRAIN.
  - DRAIN: hold until on-timer==0, then oe_n=1, plane=0, shift_row=0 → IDLE.
- Shifting the next plane overlaps display of the current plane. A plane costs max(3*COLS+1, BASE_ON<<b)+2 cycles.
- On-timer:
  - Decrements each cycle while nonzero.
  - oe_n=1 whenever on-timer==0 or blank_q=1. blank_q is blank registered once, so oe_n follows blank with 1-cycle latency.
  - Width is ADDR-independent: clog2(BASE_ON<<(DEPTH-1))+1.
- frame_start=1 during the LATCH cycle when the latched data is row 0 plane 0. This includes the first latch after IDLE.
- Before the first LATCH, oe_n stays 1, so the first plane after IDLE is never displayed with stale data.
- Simultaneous events:
  - blank and LATCH in the same cycle: oe_n=1.
  - enable falling mid-shift is ignored until RUN.
  - rd_* values are don't-care outside rd_en cycles but must hold their last value.
- Wrap-around: col, plane and row counters wrap exactly as stated. There are no skipped rows.

Test Plan:
- Reset and idle (COLS=4, ADDR_BITS=1, DEPTH=2, BASE_ON=2): assert rst_n=0 mid-shift → next edge shows oe_n=1, lat=0, hclk=0, addr=0, rd_en=0.
- Shift ordering: framebuffer returns rd_top={R=2'b10,G=2'b01,B=2'b11} for all pixels, enable=1 → plane 0 shift shows 4 hclk pulses with r0=0, g0=1, b0=1; plane 1 shows r0=1, g0=0, b0=1; rd_x sequence 0,1,2,3.
- BCM timing with BASE_ON=32, COLS=4: oe_n low 32 cycles after plane-0 latch and 64 after plane-1 latch; lat high exactly one cycle each, with oe_n=1 in that cycle.
- Row wrap and frame pulse: run 2 full frames → addr sequence 0,0,1,1,0,0,1,1 (per plane latch); frame_start pulses exactly twice, each coincident with a latch at addr=0, plane 0.
- blank: assert blank for 10 cycles during a plane display → oe_n high from the cycle after blank rises until the cycle after it falls; latch spacing unchanged.
- enable drop: deassert enable during a shift → current plane still latched and displayed for its full on-time, then oe_n=1 and FSM in IDLE; re-enable restarts at rd_row=0, plane 0 with frame_start.
